// File: rtl/arm_pkg.sv
// Shared types for the ARM fetch stage: FSM states, queue entry layout and the
// word-alignment helper used for fetch and redirect addresses.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle of the fetch stage: instruction-memory port, redirect input,
// decode-side handshake and a debug view of the fetch FSM.
//
// Handshakes: imem_req is a one-cycle pulse with imem_addr valid alongside it,
// answered by exactly one imem_rvalid pulse at least one cycle later. On the
// decode side a word transfers on every rising edge where id_valid && id_ready;
// id_valid never depends on id_ready.
interface fetch_stage_if;
    import arm_pkg::*;

    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         redir_valid;
    logic [31:0]  redir_pc;
    logic         id_valid;
    logic         id_ready;
    logic [31:0]  id_ir;
    logic [31:0]  id_pc;
    logic [31:0]  id_pc8;
    fetch_state_t dbg_state;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redir_valid, redir_pc,
        output id_valid,
        input  id_ready,
        output id_ir, id_pc, id_pc8,
        output dbg_state
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redir_valid, redir_pc,
        input  id_valid,
        output id_ready,
        input  id_ir, id_pc, id_pc8,
        input  dbg_state
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer with wrap-bit pointers. Flush beats push and pop;
// push is accepted at full only when a pop frees the head slot in the same cycle.
module fetch_queue #(
    parameter int  QDEPTH = 2,
    parameter type T      = arm_pkg::fetch_entry_t,
    localparam int PTR_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  T                 wr_data_i,
    output T                 head_o,
    output logic [PTR_W-1:0] count_o
);

    localparam int IDX_W = $clog2(QDEPTH);

    T                 mem_q [QDEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic             empty, full;
    logic             do_push, do_pop;

    assign count_o = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (count_o == PTR_W'(QDEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_q[IDX_W-1:0]];

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (flush_i) begin
            rd_d = '0;
            wr_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push) wr_d = wr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    // Storage is reset so the decode-facing fields read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q[IDX_W-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ARM instruction fetch stage: owns the fetch PC, keeps one imem read in flight,
// queues returned words with their PC and hands them to decode.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);

    localparam int PTR_W = $clog2(QDEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             run_q;
    logic             primed_q;
    logic             in_flight;
    logic             issue, push, pop, flush;
    logic [PTR_W-1:0] count;
    fetch_entry_t     wr_entry, head;

    // run_q keeps imem_req low while reset is held and for the release edge.
    assign in_flight = (state_q != IDLE);
    assign issue     = run_q && (state_q == IDLE) && !bus.redir_valid &&
                       ((count + PTR_W'(in_flight)) < PTR_W'(QDEPTH));
    assign push      = (state_q == WAIT) && bus.imem_rvalid && !bus.redir_valid;
    assign pop       = bus.id_valid && bus.id_ready;
    assign flush     = bus.redir_valid;
    assign wr_entry  = '{pc: fetch_pc_q, ir: bus.imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (issue) state_d = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = IDLE;
                    if (!bus.redir_valid) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
                end else if (bus.redir_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redir_valid) fetch_pc_d = word_align(bus.redir_pc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
            if (push) primed_q <= 1'b1;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .T      (fetch_entry_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (flush),
        .wr_data_i (wr_entry),
        .head_o    (head),
        .count_o   (count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.id_valid  = (count != '0);
    assign bus.id_ir     = head.ir;
    assign bus.id_pc     = head.pc;
    // PC+8 reads zero until the first word lands, matching the other head fields.
    assign bus.id_pc8    = primed_q ? (head.pc + 32'd8) : 32'd0;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an imem responder with programmable latency
// plus one task per scenario with hand-derived expectations.
module tb_fetch_stage;
    import arm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mem_lat = 1;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_0000;
    endfunction

    // Memory model: samples the request at the edge, answers mem_lat edges later.
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic        req_seen;
    logic [31:0] addr_seen;
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
        forever begin
            @(posedge clk);
            req_seen  = bus.imem_req;
            addr_seen = bus.imem_addr;
            #1;
            bus.imem_rvalid = 1'b0;
            if (req_seen) begin
                pend = 1'b1; pend_cnt = mem_lat; pend_addr = addr_seen;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input logic ready, input int lat);
        @(negedge clk);
        rst_n = 1'b0; bus.id_ready = ready; bus.redir_valid = 1'b0; mem_lat = lat;
        cyc(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.id_ready = 1'b0; bus.redir_valid = 1'b0; bus.redir_pc = 32'h0; mem_lat = 1;
        cyc(3);
        if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0h exp=0", bus.imem_req); end n_tests++;
        if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end n_tests++;
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", bus.id_valid); end n_tests++;
        if (bus.id_ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got=%h exp=0", bus.id_ir); end n_tests++;
        if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", bus.id_pc); end n_tests++;
        if (bus.id_pc8 !== 32'h0) begin n_fail++; $display("FAIL reset_pc8 got=%h exp=0", bus.id_pc8); end n_tests++;
        if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE); end n_tests++;
        rst_n = 1'b1;
        cyc(1);
        if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end n_tests++;
        if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got=%h exp=0", bus.imem_addr); end n_tests++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_pc   = 32'h0;
        int n_req = 0, n_pop = 0, last_req = 0;
        apply_reset(1'b1, 1);
        for (int c = 0; c < 12; c++) begin
            cyc(1);
            if (bus.imem_req === 1'b1) begin
                if (bus.imem_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr got=%h exp=%h", bus.imem_addr, exp_addr); end n_tests++;
                if (n_req > 0) begin
                    if (c - last_req != 2) begin n_fail++; $display("FAIL stream_gap got=%0d exp=2", c - last_req); end n_tests++;
                end
                last_req = c; n_req++; exp_addr += 32'd4;
            end
            if (bus.id_valid === 1'b1) begin
                if (bus.id_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc got=%h exp=%h", bus.id_pc, exp_pc); end n_tests++;
                if (bus.id_ir !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_ir got=%h exp=%h", bus.id_ir, mem_word(exp_pc)); end n_tests++;
                if (bus.id_pc8 !== exp_pc + 32'd8) begin n_fail++; $display("FAIL stream_pc8 got=%h exp=%h", bus.id_pc8, exp_pc + 32'd8); end n_tests++;
                exp_pc += 32'd4; n_pop++;
            end
        end
        if (n_req != 6) begin n_fail++; $display("FAIL stream_nreq got=%0d exp=6", n_req); end n_tests++;
        if (n_pop != 5) begin n_fail++; $display("FAIL stream_npop got=%0d exp=5", n_pop); end n_tests++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        apply_reset(1'b0, 1);
        cyc(3);
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_second_req got=%0h/%h exp=1/4", bus.imem_req, bus.imem_addr); end n_tests++;
        cyc(1);
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) bad++;
        end
        if (bad != 0) begin n_fail++; $display("FAIL bp_full_hold got=%0d bad cycles exp=0", bad); end n_tests++;
        bus.id_ready = 1'b1;
        cyc(1);
        if (bus.id_pc !== 32'h4 || bus.id_ir !== mem_word(32'h4)) begin n_fail++; $display("FAIL bp_second_pop got=%h/%h exp=4/%h", bus.id_pc, bus.id_ir, mem_word(32'h4)); end n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume got=%0h/%h exp=1/8", bus.imem_req, bus.imem_addr); end n_tests++;
        cyc(1);
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%0h exp=0", bus.id_valid); end n_tests++;
        cyc(1);
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin n_fail++; $display("FAIL bp_third got=%0h/%h exp=1/8", bus.id_valid, bus.id_pc); end n_tests++;
        bus.id_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int bad = 0;
        apply_reset(1'b1, 3);
        cyc(2);
        if (bus.dbg_state !== WAIT) begin n_fail++; $display("FAIL rw_wait got=%0d exp=%0d", bus.dbg_state, WAIT); end n_tests++;
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_1003;
        cyc(1);
        bus.redir_valid = 1'b0;
        #1;
        if (bus.dbg_state !== DRAIN || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_drain got=%0d/%0h exp=%0d/0", bus.dbg_state, bus.imem_req, DRAIN); end n_tests++;
        cyc(1);
        if (bus.dbg_state !== DRAIN) begin n_fail++; $display("FAIL rw_drain_hold got=%0d exp=%0d", bus.dbg_state, DRAIN); end n_tests++;
        cyc(1);
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000) begin n_fail++; $display("FAIL rw_target got=%0h/%h exp=1/1000", bus.imem_req, bus.imem_addr); end n_tests++;
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale_dropped got=%0h exp=0", bus.id_valid); end n_tests++;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            if (bus.id_valid !== 1'b0) bad++;
        end
        if (bad != 0) begin n_fail++; $display("FAIL rw_empty got=%0d bad cycles exp=0", bad); end n_tests++;
        cyc(1);
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h1000) begin n_fail++; $display("FAIL rw_first got=%0h/%h exp=1/1000", bus.id_valid, bus.id_pc); end n_tests++;
        if (bus.id_ir !== mem_word(32'h1000) || bus.id_pc8 !== 32'h1008) begin n_fail++; $display("FAIL rw_first_data got=%h/%h exp=%h/1008", bus.id_ir, bus.id_pc8, mem_word(32'h1000)); end n_tests++;
    endtask

    task automatic test_redirect_rvalid();
        apply_reset(1'b0, 1);
        cyc(2);
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_2000;
        cyc(1);
        bus.redir_valid = 1'b0;
        #1;
        if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL rr_no_drain got=%0d exp=%0d", bus.dbg_state, IDLE); end n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rr_target got=%0h/%h exp=1/2000", bus.imem_req, bus.imem_addr); end n_tests++;
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL rr_dropped got=%0h exp=0", bus.id_valid); end n_tests++;
        cyc(2);
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h2000 || bus.id_ir !== mem_word(32'h2000)) begin n_fail++; $display("FAIL rr_first got=%0h/%h/%h exp=1/2000/%h", bus.id_valid, bus.id_pc, bus.id_ir, mem_word(32'h2000)); end n_tests++;
    endtask

    task automatic test_full_redirect();
        apply_reset(1'b0, 1);
        cyc(5);
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        #1;
        if (bus.id_pc !== 32'h4 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL fr_refill got=%h/%0h/%h exp=4/1/8", bus.id_pc, bus.imem_req, bus.imem_addr); end n_tests++;
        cyc(1);
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        #1;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin n_fail++; $display("FAIL fr_push_pop got=%0h/%h exp=1/8", bus.id_valid, bus.id_pc); end n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL fr_next_req got=%0h/%h exp=1/c", bus.imem_req, bus.imem_addr); end n_tests++;
        cyc(2);
        if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin n_fail++; $display("FAIL fr_full got=%0h/%0h/%h exp=0/1/8", bus.imem_req, bus.id_valid, bus.id_pc); end n_tests++;
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_3000; bus.id_ready = 1'b1;
        cyc(1);
        bus.redir_valid = 1'b0; bus.id_ready = 1'b0;
        #1;
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fr_flushed got=%0h exp=0", bus.id_valid); end n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL fr_target got=%0h/%h exp=1/3000", bus.imem_req, bus.imem_addr); end n_tests++;
        cyc(2);
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h3000) begin n_fail++; $display("FAIL fr_first got=%0h/%h exp=1/3000", bus.id_valid, bus.id_pc); end n_tests++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        apply_reset(1'b0, 1);
        cyc(3);
        if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL rm_pre_addr got=%h exp=4", bus.imem_addr); end n_tests++;
        mem_lat = 3;
        cyc(1);
        if (bus.dbg_state !== WAIT || bus.id_pc8 !== 32'h8) begin n_fail++; $display("FAIL rm_pre_state got=%0d/%h exp=%0d/8", bus.dbg_state, bus.id_pc8, WAIT); end n_tests++;
        rst_n = 1'b0;
        #1;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_req got=%0h/%h exp=0/0", bus.imem_req, bus.imem_addr); end n_tests++;
        if (bus.id_valid !== 1'b0 || bus.id_ir !== 32'h0) begin n_fail++; $display("FAIL rm_id got=%0h/%h exp=0/0", bus.id_valid, bus.id_ir); end n_tests++;
        if (bus.id_pc !== 32'h0 || bus.id_pc8 !== 32'h0) begin n_fail++; $display("FAIL rm_pc got=%h/%h exp=0/0", bus.id_pc, bus.id_pc8); end n_tests++;
        if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL rm_state got=%0d exp=%0d", bus.dbg_state, IDLE); end n_tests++;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_refetch got=%0h/%h exp=1/0", bus.imem_req, bus.imem_addr); end n_tests++;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            if (bus.id_valid !== 1'b0) bad++;
        end
        if (bad != 0) begin n_fail++; $display("FAIL rm_stale_ignored got=%0d bad cycles exp=0", bad); end n_tests++;
        cyc(1);
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_ir !== mem_word(32'h0)) begin n_fail++; $display("FAIL rm_first got=%0h/%h/%h exp=1/0/%h", bus.id_valid, bus.id_pc, bus.id_ir, mem_word(32'h0)); end n_tests++;
        mem_lat = 1;
    endtask

    initial begin
        bus.id_ready    = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_full_redirect();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
